// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - iterative multiply/divide unit, one bit per clock, start/busy/done handshake
// Optional: ALU_ITER_EARLY_TERM_EN lets MULU finish once the remaining multiplier bits are zero.
module alu_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] OP_MULU = 2'b00;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             dz_q, dz_d;

    logic             sa, sb;
    logic [WIDTH-1:0] ma, mb;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic             div_ge, last;
    logic [WIDTH-1:0] step_acc, step_q, quot, rem;
    logic [2*WIDTH-1:0] prod_mag, prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            res_q    <= '0;
            res_hi_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            m_q      <= m_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        // Operand magnitudes; signed ops are computed unsigned and fixed up at the end
        sa = op[1] & a[WIDTH-1];
        sb = op[1] & b[WIDTH-1];
        ma = sa ? -a : a;
        mb = sb ? -b : b;

        // Multiply: right-shifting shift-add, product forms in {acc, q}
        mul_sum = {1'b0, acc_q} + ({1'b0, m_q} & {(WIDTH+1){q_q[0]}});

        // Divide: restoring step, remainder in acc, quotient shifts into q
        div_sh   = {acc_q, q_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, m_q};
        div_ge   = ~div_diff[WIDTH];

        if (op_q[0]) begin
            step_acc = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            step_q   = {q_q[WIDTH-2:0], div_ge};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_q   = {mul_sum[0], q_q[WIDTH-1:1]};
        end

        prod_mag = {step_acc, step_q};
        last     = (cnt_q == CW'(1));
`ifdef ALU_ITER_EARLY_TERM_EN
        if (op_q == OP_MULU) begin
            if (q_q[WIDTH-1:1] == '0) last = 1'b1;
            // Skipped steps would only shift right; apply them all at once
            prod_mag = prod_mag >> (cnt_q - CW'(1));
        end
`endif
        prod = neg_lo_q ? -prod_mag : prod_mag;
        quot = neg_lo_q ? -step_q : step_q;
        rem  = neg_hi_q ? -step_acc : step_acc;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        m_d      = m_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        dz_d     = dz_q;

        case (state_q)
            S_RUN: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q - CW'(1);
                if (last) begin
                    state_d = S_DONE;
                    if (op_q[0]) begin
                        res_d    = quot;
                        res_hi_d = rem;
                    end else begin
                        res_d    = prod[WIDTH-1:0];
                        res_hi_d = prod[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: begin
                if (state_q == S_DONE) state_d = S_IDLE;
                if (start) begin
                    op_d     = op;
                    dz_d     = 1'b0;
                    cnt_d    = CW'(WIDTH);
                    acc_d    = '0;
                    neg_lo_d = sa ^ sb;
                    neg_hi_d = sa;
                    q_d      = op[0] ? ma : mb;
                    m_d      = op[0] ? mb : ma;
                    if (op[0] && (b == '0)) begin
                        state_d  = S_DONE;
                        res_d    = '1;
                        res_hi_d = a;
                        dz_d     = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
        endcase
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign res      = res_q;
    assign res_hi   = res_hi_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - self-checking bench for alu_iter against an arithmetic reference model
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [15:0] a_i = 16'h0;
    logic [15:0] b_i = 16'h0;
    logic        busy, done, div_zero;
    logic [15:0] res, res_hi;

    int n_cmp = 0;
    int n_bad = 0;

    alu_iter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op_i), .a(a_i), .b(b_i),
        .busy(busy), .done(done), .res(res), .res_hi(res_hi), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [15:0] rh, output logic dz);
        longint sa, sb, p;
        logic [31:0] pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        r  = '0;
        rh = '0;
        case (op)
            2'b00: begin pv = 32'(a) * 32'(b); r = pv[15:0]; rh = pv[31:16]; end
            2'b10: begin p = sa * sb; pv = p[31:0]; r = pv[15:0]; rh = pv[31:16]; end
            default: begin
                if (b == 16'h0) begin
                    r = 16'hFFFF; rh = a; dz = 1'b1;
                end else if (op == 2'b01) begin
                    r = a / b; rh = a % b;
                end else begin
                    p = sa / sb; r = p[15:0];
                    p = sa % sb; rh = p[15:0];
                end
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [15:0] b);
        int h;
        if (op[0] && b == 16'h0) return 0;
`ifdef ALU_ITER_EARLY_TERM_EN
        if (op == 2'b00) begin
            h = 0;
            for (int i = 0; i < 16; i++) if (b[i]) h = i;
            return h + 1;
        end
`endif
        h = 16;
        return h;
    endfunction

    // Call away from a clock edge; returns one time unit after the accepting edge
    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        op_i = op; a_i = a; b_i = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_i = 2'($urandom); a_i = 16'($urandom); b_i = 16'($urandom);
    endtask

    task automatic collect(input string tag, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, input int poke);
        logic [15:0] er, erh;
        logic        edz;
        int          j, busy_n, lat;
        bit          seen;
        model(op, a, b, er, erh, edz);
        lat = exp_lat(op, b);
        j = 0; busy_n = 0; seen = 0;
        while (!seen && j <= 40) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) busy_n++;
                start = (j == poke);
                if (start) begin
                    op_i = 2'($urandom); a_i = 16'($urandom); b_i = 16'($urandom);
                end
                @(posedge clk); #1;
                j++;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(j), 32'(lat));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat));
        if (seen) begin
            chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
            chk({tag, "_res"}, {16'b0, res}, {16'b0, er});
            chk({tag, "_res_hi"}, {16'b0, res_hi}, {16'b0, erh});
            chk({tag, "_div_zero"}, {31'b0, div_zero}, {31'b0, edz});
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        issue(op, a, b);
        collect(tag, op, a, b, -1);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [15:0] ra, rb;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_res", {16'b0, res}, 32'd0);
        chk("rst_res_hi", {16'b0, res_hi}, 32'd0);
        chk("rst_div_zero", {31'b0, div_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run("mulu_basic", 2'b00, 16'h1234, 16'h0010);
        chk("mulu_basic_const_lo", {16'b0, res}, 32'h2340);
        chk("mulu_basic_const_hi", {16'b0, res_hi}, 32'h0001);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("res_held", {16'b0, res}, 32'h2340);
        run("muls_neg", 2'b10, 16'hFFFD, 16'h0007);
        run("muls_min", 2'b10, 16'h8000, 16'h8000);
        run("mulu_zero", 2'b00, 16'hBEEF, 16'h0000);
        run("mulu_max", 2'b00, 16'hFFFF, 16'hFFFF);
        run("divu_basic", 2'b01, 16'h0064, 16'h0007);
        run("divs_neg", 2'b11, 16'hFFF9, 16'h0002);
        run("divs_ovf", 2'b11, 16'h8000, 16'hFFFF);
        run("divs_negdiv", 2'b11, 16'h0007, 16'hFFFE);
        run("divu_zero", 2'b01, 16'h00AB, 16'h0000);
        chk("divu_zero_const_res", {16'b0, res}, 32'hFFFF);
        run("divu_after_zero", 2'b01, 16'h1000, 16'h0003);
        run("divs_zero", 2'b11, 16'h8001, 16'h0000);

        // start mid-RUN is ignored
        @(negedge clk);
        issue(2'b01, 16'hC350, 16'h00FB);
        collect("ignore_start", 2'b01, 16'hC350, 16'h00FB, 3);

        // Back-to-back: start accepted while done is high
        @(negedge clk);
        issue(2'b10, 16'h7FFF, 16'h8000);
        collect("b2b_first", 2'b10, 16'h7FFF, 16'h8000, -1);
        issue(2'b11, 16'hFF9C, 16'h0009);
        collect("b2b_second", 2'b11, 16'hFF9C, 16'h0009, -1);
        issue(2'b01, 16'h0005, 16'h0000);
        collect("b2b_divzero", 2'b01, 16'h0005, 16'h0000, -1);
        @(posedge clk); #1;
        chk("b2b_done_drop", {31'b0, done}, 32'd0);

        // Reset mid-RUN aborts immediately with no done pulse
        @(negedge clk);
        issue(2'b00, 16'h1234, 16'h8765);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_res", {16'b0, res}, 32'd0);
        chk("abort_res_hi", {16'b0, res_hi}, 32'd0);
        chk("abort_div_zero", {31'b0, div_zero}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("after_abort", 2'b00, 16'h00FF, 16'h0101);

        // Randomized operations against the reference model
        for (int k = 0; k < 40; k++) begin
            rop = 2'($urandom);
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 9) == 0) ra = 16'h8000;
            if ($urandom_range(0, 9) == 0) rb = 16'hFFFF;
            run("rand", rop, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
